// File: rtl/cu_fsm.sv
// Multicycle control-unit FSM for the OTTER RV32I core: fetch, execute, load writeback and
// interrupt entry, with Mealy strobe decode and a retired-instruction counter.
module cu_fsm #(
  parameter int unsigned LOAD_WAIT = 0,
  parameter int unsigned CNT_W     = 32
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [6:0]       OPCODE,
  input  logic [2:0]       FUNC3,
  input  logic             INTR,
  input  logic             CSR_MIE,
  output logic             PC_WRITE,
  output logic             REG_WRITE,
  output logic             MEM_RDEN1,
  output logic             MEM_RDEN2,
  output logic             MEM_WE2,
  output logic             CSR_WE,
  output logic             INT_TAKEN,
  output logic [1:0]       STATE,
  output logic [CNT_W-1:0] RETIRED_CNT
);

  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpOp     = 7'b0110011;
  localparam logic [6:0] OpOpImm  = 7'b0010011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpSystem = 7'b1110011;

  localparam logic [3:0] WaitMax  = 4'(LOAD_WAIT);

  typedef enum logic [1:0] {
    StFetch = 2'd0,
    StExec  = 2'd1,
    StWb    = 2'd2,
    StIntr  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [3:0]       wait_q, wait_d;
  logic [CNT_W-1:0] cnt_q;
  logic             int_pend;
  logic             retire;

  assign int_pend    = INTR & CSR_MIE;
  assign retire      = PC_WRITE & (state_q != StIntr);
  assign STATE       = state_q;
  assign RETIRED_CNT = cnt_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= StFetch;
      wait_q  <= 4'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      if (retire) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Interrupt pending is only looked at in the cycle that completes an instruction.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    case (state_q)
      StFetch: state_d = StExec;
      StExec: begin
        if (OPCODE == OpLoad) begin
          state_d = StWb;
          wait_d  = 4'd0;
        end else begin
          state_d = int_pend ? StIntr : StFetch;
        end
      end
      StWb: begin
        if (wait_q == WaitMax) begin
          wait_d  = 4'd0;
          state_d = int_pend ? StIntr : StFetch;
        end else begin
          wait_d = wait_q + 4'd1;
        end
      end
      StIntr:  state_d = StFetch;
      default: state_d = StFetch;
    endcase
  end

  // Strobes are held low while reset is asserted, even mid-instruction.
  always_comb begin
    PC_WRITE  = 1'b0;
    REG_WRITE = 1'b0;
    MEM_RDEN1 = 1'b0;
    MEM_RDEN2 = 1'b0;
    MEM_WE2   = 1'b0;
    CSR_WE    = 1'b0;
    INT_TAKEN = 1'b0;
    if (RST_N) begin
      case (state_q)
        StFetch: MEM_RDEN1 = 1'b1;
        StExec: begin
          case (OPCODE)
            OpLui, OpAuipc, OpJal, OpJalr, OpOp, OpOpImm: begin
              REG_WRITE = 1'b1;
              PC_WRITE  = 1'b1;
            end
            OpStore: begin
              MEM_WE2  = 1'b1;
              PC_WRITE = 1'b1;
            end
            OpLoad:  MEM_RDEN2 = 1'b1;
            OpSystem: begin
              PC_WRITE = 1'b1;
              if (FUNC3 != 3'b000) begin
                CSR_WE    = 1'b1;
                REG_WRITE = 1'b1;
              end
            end
            default: PC_WRITE = 1'b1;
          endcase
        end
        StWb: begin
          MEM_RDEN2 = 1'b1;
          if (wait_q == WaitMax) begin
            REG_WRITE = 1'b1;
            PC_WRITE  = 1'b1;
          end
        end
        StIntr: begin
          INT_TAKEN = 1'b1;
          PC_WRITE  = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cu_fsm.sv
// Bench for cu_fsm: a directed cycle table, directed corner sequences and random stimulus,
// all checked against an instruction-level reference model for two parameterisations.
module tb_cu_fsm;

  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpOp     = 7'b0110011;
  localparam logic [6:0] OpOpImm  = 7'b0010011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpSystem = 7'b1110011;
  localparam logic [6:0] OpBad    = 7'b1111111;

  // Strobe vector order: {pc_write, reg_write, rden1, rden2, we2, csr_we, int_taken}
  localparam logic [6:0] SFetch = 7'b0010000;
  localparam logic [6:0] SAlu   = 7'b1100000;
  localparam logic [6:0] SLoad  = 7'b0001000;
  localparam logic [6:0] SWbEnd = 7'b1101000;
  localparam logic [6:0] SStore = 7'b1000100;
  localparam logic [6:0] SCsr   = 7'b1100010;
  localparam logic [6:0] SPcOnly = 7'b1000000;
  localparam logic [6:0] SIntr  = 7'b1000001;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [6:0] opcode = OpOpImm;
  logic [2:0] func3 = 3'd0;
  logic intr = 1'b0;
  logic csr_mie = 1'b0;

  logic pcw0, rw0, rd1_0, rd2_0, we0, cw0, it0;
  logic [1:0] st0;
  logic [31:0] cnt0;
  logic pcw1, rw1, rd1_1, rd2_1, we1, cw1, it1;
  logic [1:0] st1;
  logic [2:0] cnt1;

  always #5 clk = ~clk;

  cu_fsm #(.LOAD_WAIT(2), .CNT_W(32)) u_dut0 (
    .CLK(clk), .RST_N(rst_n), .OPCODE(opcode), .FUNC3(func3), .INTR(intr), .CSR_MIE(csr_mie),
    .PC_WRITE(pcw0), .REG_WRITE(rw0), .MEM_RDEN1(rd1_0), .MEM_RDEN2(rd2_0), .MEM_WE2(we0),
    .CSR_WE(cw0), .INT_TAKEN(it0), .STATE(st0), .RETIRED_CNT(cnt0)
  );

  cu_fsm #(.LOAD_WAIT(1), .CNT_W(3)) u_dut1 (
    .CLK(clk), .RST_N(rst_n), .OPCODE(opcode), .FUNC3(func3), .INTR(intr), .CSR_MIE(csr_mie),
    .PC_WRITE(pcw1), .REG_WRITE(rw1), .MEM_RDEN1(rd1_1), .MEM_RDEN2(rd2_1), .MEM_WE2(we1),
    .CSR_WE(cw1), .INT_TAKEN(it1), .STATE(st1), .RETIRED_CNT(cnt1)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Model: phase 0 fetch, 1 execute, 2 writeback (j = WB cycles already spent), 3 int entry.
  int          m_ph[2]   = '{0, 0};
  int          m_j[2]    = '{0, 0};
  logic [31:0] m_cnt[2]  = '{32'd0, 32'd0};
  int          lw_k[2]   = '{2, 1};
  logic [31:0] mask_k[2] = '{32'hFFFF_FFFF, 32'h0000_0007};

  typedef struct {
    logic        rst;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        irq;
    logic        mie;
    logic [1:0]  st;
    logic [6:0]  stb;
    logic [31:0] cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [40:0] act(int k);
    if (k == 0) return {st0, pcw0, rw0, rd1_0, rd2_0, we0, cw0, it0, cnt0};
    return {st1, pcw1, rw1, rd1_1, rd2_1, we1, cw1, it1, 29'd0, cnt1};
  endfunction

  function automatic logic [6:0] model_stb(int ph, int j, int lw, logic [6:0] op,
                                           logic [2:0] f3);
    case (ph)
      0: return SFetch;
      1: begin
        if (op == OpLoad) return SLoad;
        if (op == OpStore) return SStore;
        if (op == OpSystem) return (f3 != 3'd0) ? SCsr : SPcOnly;
        if (op inside {OpLui, OpAuipc, OpJal, OpJalr, OpOp, OpOpImm}) return SAlu;
        return SPcOnly;
      end
      2: return (j == lw) ? SWbEnd : SLoad;
      default: return SIntr;
    endcase
  endfunction

  task automatic check(string name, logic [40:0] got, logic [40:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s @%0t: got st=%0d stb=%b cnt=%0d, want st=%0d stb=%b cnt=%0d",
               name, $time, got[40:39], got[38:32], got[31:0],
               want[40:39], want[38:32], want[31:0]);
    end
  endtask

  // Called at the negedge: compare both DUTs to the model, then advance the model.
  task automatic model_check();
    for (int k = 0; k < 2; k++) begin
      logic [6:0] stb;
      logic       pend;
      if (!rst_n) begin
        m_ph[k] = 0;
        m_j[k] = 0;
        m_cnt[k] = 32'd0;
        check($sformatf("model_rst dut%0d", k), act(k), 41'd0);
      end else begin
        stb = model_stb(m_ph[k], m_j[k], lw_k[k], opcode, func3);
        check($sformatf("model dut%0d", k), act(k), {m_ph[k][1:0], stb, m_cnt[k]});
        if (stb[6] && m_ph[k] != 3) m_cnt[k] = (m_cnt[k] + 32'd1) & mask_k[k];
        pend = intr & csr_mie;
        case (m_ph[k])
          0: m_ph[k] = 1;
          1: begin
            if (opcode == OpLoad) begin
              m_ph[k] = 2;
              m_j[k] = 0;
            end else begin
              m_ph[k] = pend ? 3 : 0;
            end
          end
          2: begin
            if (m_j[k] == lw_k[k]) begin
              m_j[k] = 0;
              m_ph[k] = pend ? 3 : 0;
            end else begin
              m_j[k]++;
            end
          end
          default: m_ph[k] = 0;
        endcase
      end
    end
  endtask

  task automatic drive(logic r, logic [6:0] op, logic [2:0] f3, logic irq, logic mie);
    @(posedge clk);
    #1;
    rst_n = r;
    opcode = op;
    func3 = f3;
    intr = irq;
    csr_mie = mie;
    @(negedge clk);
    model_check();
  endtask

  task automatic add(logic r, logic [6:0] op, logic [2:0] f3, logic irq, logic mie,
                     logic [1:0] st, logic [6:0] stb, logic [31:0] cnt);
    vec_t v;
    v = '{r, op, f3, irq, mie, st, stb, cnt};
    tbl.push_back(v);
  endtask

  logic [6:0] ops[11] = '{OpLui, OpAuipc, OpJal, OpJalr, OpOp, OpOpImm, OpBranch, OpStore,
                          OpLoad, OpSystem, OpBad};

  initial begin
    // Directed cycle table for dut0 (LOAD_WAIT=2).
    add(0, OpOpImm,  3'd0, 0, 0, 2'd0, 7'd0,    0);
    add(1, OpOpImm,  3'd0, 0, 0, 2'd0, SFetch,  0);
    add(1, OpOpImm,  3'd0, 0, 0, 2'd1, SAlu,    0);
    add(1, OpOpImm,  3'd0, 0, 0, 2'd0, SFetch,  1);
    add(1, OpOpImm,  3'd0, 0, 0, 2'd1, SAlu,    1);
    add(1, OpLoad,   3'd2, 0, 0, 2'd0, SFetch,  2);
    add(1, OpLoad,   3'd2, 0, 0, 2'd1, SLoad,   2);
    add(1, OpLoad,   3'd2, 0, 0, 2'd2, SLoad,   2);
    add(1, OpLoad,   3'd2, 0, 0, 2'd2, SLoad,   2);
    add(1, OpLoad,   3'd2, 0, 0, 2'd2, SWbEnd,  2);
    add(1, OpStore,  3'd2, 0, 0, 2'd0, SFetch,  3);
    add(1, OpStore,  3'd2, 0, 0, 2'd1, SStore,  3);
    add(1, OpSystem, 3'd1, 0, 0, 2'd0, SFetch,  4);
    add(1, OpSystem, 3'd1, 0, 0, 2'd1, SCsr,    4);
    add(1, OpSystem, 3'd0, 0, 0, 2'd0, SFetch,  5);
    add(1, OpSystem, 3'd0, 0, 0, 2'd1, SPcOnly, 5);
    add(1, OpOp,     3'd0, 1, 1, 2'd0, SFetch,  6);
    add(1, OpOp,     3'd0, 1, 1, 2'd1, SAlu,    6);
    add(1, OpOp,     3'd0, 1, 1, 2'd3, SIntr,   7);
    add(1, OpOp,     3'd0, 1, 0, 2'd0, SFetch,  7);
    add(1, OpOp,     3'd0, 1, 0, 2'd1, SAlu,    7);
    add(1, OpBad,    3'd0, 0, 0, 2'd0, SFetch,  8);
    add(1, OpBad,    3'd0, 0, 0, 2'd1, SPcOnly, 8);
    add(1, OpLoad,   3'd0, 0, 0, 2'd0, SFetch,  9);
    add(1, OpLoad,   3'd0, 0, 0, 2'd1, SLoad,   9);
    add(1, OpLoad,   3'd0, 0, 0, 2'd2, SLoad,   9);
    add(0, OpLoad,   3'd0, 0, 0, 2'd0, 7'd0,    0);
    add(1, OpOpImm,  3'd0, 0, 0, 2'd0, SFetch,  0);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rst, tbl[i].op, tbl[i].f3, tbl[i].irq, tbl[i].mie);
      check($sformatf("tbl[%0d]", i), act(0), {tbl[i].st, tbl[i].stb, tbl[i].cnt});
    end

    // dut1 (LOAD_WAIT=1): interrupt pulse only in the first WB cycle must not be taken.
    drive(0, OpOpImm, 3'd0, 0, 0);
    drive(1, OpLoad, 3'd0, 0, 1);
    drive(1, OpLoad, 3'd0, 0, 1);
    drive(1, OpLoad, 3'd0, 1, 1);
    drive(1, OpLoad, 3'd0, 0, 1);
    drive(1, OpOpImm, 3'd0, 0, 1);
    check("pulse_no_entry", {st1, it1, 38'd0, pcw1}, {2'd0, 1'b0, 38'd0, 1'b0});

    // dut1 (CNT_W=3): the retired counter wraps from 7 to 0.
    drive(0, OpOpImm, 3'd0, 0, 0);
    for (int i = 0; i < 7; i++) begin
      drive(1, OpOpImm, 3'd0, 0, 0);
      drive(1, OpOpImm, 3'd0, 0, 0);
    end
    drive(1, OpOpImm, 3'd0, 0, 0);
    check("cnt_at_max", {38'd0, cnt1}, 41'd7);
    drive(1, OpOpImm, 3'd0, 0, 0);
    drive(1, OpOpImm, 3'd0, 0, 0);
    check("cnt_wrap", {38'd0, cnt1}, 41'd0);

    // Random stimulus against the model.
    for (int i = 0; i < 2000; i++) begin
      drive(($urandom_range(0, 149) != 0), ops[$urandom_range(0, 10)],
            3'($urandom_range(0, 7)), ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cu_fsm.md
Name: cu_fsm

Overview:
Multicycle control-unit state machine for the OTTER RV32I core. Sequences fetch, execute, load writeback and interrupt entry. Drives the PC, register file, memory and CSR write strobes. Works alongside the combinational decoder: INT_TAKEN from this block tells the decoder to select the interrupt PC source. Also keeps a retired-instruction counter for debug and perf.

Parameters:
LOAD_WAIT, 0, extra WB cycles spent waiting for memory read data before the register write (0..15)
CNT_W, 32, width of RETIRED_CNT

Ports:
CLK  in  1  system clock, rising edge
RST_N  in  1  asynchronous active-low reset
OPCODE  in  7  instruction[6:0] from memory port 1
FUNC3  in  3  instruction[14:12]
INTR  in  1  external interrupt request, level, synchronous to CLK
CSR_MIE  in  1  global interrupt enable (mstatus.MIE) from the CSR file
PC_WRITE  out  1  PC register load enable
REG_WRITE  out  1  register file write enable
MEM_RDEN1  out  1  instruction read enable
MEM_RDEN2  out  1  data read enable
MEM_WE2  out  1  data write enable
CSR_WE  out  1  CSR file write enable
INT_TAKEN  out  1  interrupt entry strobe; decoder forces PC_SOURCE=4 and the CSR file saves mepc
STATE  out  2  current state, debug: FETCH=0, EXEC=1, WB=2, INTR=3
RETIRED_CNT  out  CNT_W  count of retired instructions

Behaviour:
- RST_N low: state <= FETCH asynchronously, wait counter <= 0, RETIRED_CNT <= 0. All strobe outputs are forced 0 while RST_N is low, including mid-instruction; STATE reads 0.
- Outputs are a combinational decode of state plus OPCODE/FUNC3 (Mealy). Strobes are 1-cycle pulses, except MEM_RDEN2, which is held through WB.
- FETCH:
  - MEM_RDEN1=1.
  - Next state EXEC.
  - Interrupts are never taken from FETCH.
- EXEC, by opcode:
  - LUI/AUIPC/JAL/JALR/OP/OP_IMM (0110111/0010111/1101111/1100111/0110011/0010011): REG_WRITE=1, PC_WRITE=1.
  - BRANCH 1100011: PC_WRITE=1.
  - STORE 0100011: MEM_WE2=1, PC_WRITE=1.
  - LOAD 0000011: MEM_RDEN2=1, no PC_WRITE; next state WB.
  - SYSTEM 1110011 with FUNC3!=000 (CSRRW/S/C): CSR_WE=1, REG_WRITE=1, PC_WRITE=1.
  - SYSTEM with FUNC3==000 (MRET): PC_WRITE=1 only.
  - Any other opcode: PC_WRITE=1 only (executes as a NOP and retires).
  - Next state for non-LOAD: INTR if (INTR & CSR_MIE) is sampled in this cycle, else FETCH.
- WB:
  - MEM_RDEN2=1 every WB cycle.
  - Wait counter counts 0..LOAD_WAIT.
  - While counter < LOAD_WAIT: no other strobes, stay in WB.
  - When counter == LOAD_WAIT: REG_WRITE=1, PC_WRITE=1, counter <= 0, next state INTR if (INTR & CSR_MIE), else FETCH.
  - LOAD_WAIT=0 gives exactly one WB cycle.
- INTR:
  - INT_TAKEN=1, PC_WRITE=1.
  - Next state FETCH unconditionally.
  - Not a retirement.
- Interrupt pending is sampled only in the completing cycle of an instruction (EXEC non-load, or final WB). INTR deasserting before that cycle means no entry. INTR held high re-enters only after the handler instruction completes and only if CSR_MIE is 1. The CSR file clears MIE on entry, so there is no back-to-back entry.
- RETIRED_CNT increments by 1 on each cycle with PC_WRITE=1 and state != INTR. It wraps from all-ones to 0 without saturating.
- Instruction latency:
  - Non-load: 2 cycles.
  - Load: 3+LOAD_WAIT cycles.
  - Interrupt entry: +1 cycle.

Test Plan:
- Reset then ADDI (OPCODE 0010011) fetched repeatedly -> STATE sequence 0,1,0,1. REG_WRITE and PC_WRITE high only in EXEC. RETIRED_CNT=2 after 4 cycles.
- LW with LOAD_WAIT=2 -> EXEC (MEM_RDEN2=1, PC_WRITE=0), then WB for 3 cycles with MEM_RDEN2=1. REG_WRITE=PC_WRITE=1 only in the 3rd WB cycle. Total 5 cycles.
- SW, then CSRRW (FUNC3=001), then MRET (FUNC3=000) -> SW: MEM_WE2=1 in EXEC. CSRRW: CSR_WE=1 and REG_WRITE=1. MRET: PC_WRITE only, CSR_WE=0.
- INTR=1, CSR_MIE=1 raised during FETCH of an OP instruction -> EXEC then INTR state with INT_TAKEN=1, PC_WRITE=1, then FETCH. RETIRED_CNT +1, not +2. With CSR_MIE=0 -> no INTR state.
- INTR pulsed high only during the first WB cycle of a load with LOAD_WAIT=1 -> no interrupt entry; returns to FETCH.
- RST_N dropped mid-WB -> all strobes 0 in the same cycle, STATE=0, RETIRED_CNT=0. After release, first cycle is FETCH with MEM_RDEN1=1. Force RETIRED_CNT to all-ones and retire one instruction -> wraps to 0.
